// File: rtl/neuron_pkg.sv
// Shared constants, state encoding and saturation helper for the fixed-point neuron.
package neuron_pkg;

    localparam logic [1:0] ACT_IDENT = 2'b00;
    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_LEAKY = 2'b10;
    localparam logic [1:0] ACT_RSVD  = 2'b11;

    localparam int unsigned LEAKY_SHIFT = 3;
    localparam int unsigned SAT_W       = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    // Clamp a sign-extended sum to an n-bit signed range; returns {overflow, clamped value}.
    function automatic logic [SAT_W:0] sat_to_n(input logic signed [SAT_W-1:0] value,
                                                input int unsigned n);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (n - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return {1'b1, max_v};
        end
        if (value < min_v) begin
            return {1'b1, min_v};
        end
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/neuron_activation.sv
// Combinational activation (identity / ReLU / leaky ReLU) followed by N-bit saturation.
module neuron_activation
    import neuron_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 28
) (
    input  logic signed [ACC_W-1:0] sum,
    input  logic        [1:0]       act_mode,
    output logic        [N-1:0]     result_c,
    output logic                    overflow_c
);

    logic signed [ACC_W-1:0] act_c;
    logic        [SAT_W:0]   sat_c;
    logic                    unused_hi_c;

    always_comb begin
        act_c = sum;
        case (act_mode)
            ACT_RELU:  if (sum[ACC_W-1]) act_c = '0;
            ACT_LEAKY: if (sum[ACC_W-1]) act_c = sum >>> LEAKY_SHIFT;
            default:   act_c = sum;
        endcase
        sat_c = sat_to_n(SAT_W'(act_c), N);
    end

    assign result_c    = sat_c[N-1:0];
    assign overflow_c  = sat_c[SAT_W];
    assign unused_hi_c = ^sat_c[SAT_W-1:N];

endmodule

// File: rtl/neuron_pipe.sv
// Fixed-point neuron: LANES-wide multiply-accumulate over NUM_INPUTS pairs plus bias,
// activation and saturation, with valid/ready on both sides.
module neuron_pipe
    import neuron_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned M          = 8,
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned LANES      = 2,
    parameter int unsigned ACC_GUARD  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_INPUTS*N-1:0] datas,
    input  logic [NUM_INPUTS*N-1:0] weights,
    input  logic [N-1:0]            bias,
    input  logic [1:0]              act_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            result,
    output logic                    overflow
);

    localparam int unsigned ACC_W  = N + ACC_GUARD;
    localparam int unsigned BEATS  = NUM_INPUTS / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned VEC_W  = NUM_INPUTS * N;
    localparam int unsigned PROD_W = 2 * N;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [VEC_W-1:0]        datas_q, datas_d;
    logic [VEC_W-1:0]        weights_q, weights_d;
    logic [N-1:0]            bias_q, bias_d;
    logic [1:0]              mode_q, mode_d;
    logic [N-1:0]            result_q, result_d;
    logic                    overflow_q, overflow_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0]  lane_sum_c;
    logic signed [ACC_W-1:0]  acc_sum_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [N-1:0]             act_result_c;
    logic                     act_overflow_c;
    logic                     accept_c;
    int                       idx_c;

    assign in_ready = ((state_q == ST_IDLE) | ((state_q == ST_OUTPUT) & out_ready))
                      & clk_en & ~rst;
    assign accept_c = in_valid & in_ready;

    // Products of this beat's lanes, floored back to Q.M, summed into the running total.
    always_comb begin
        lane_sum_c = '0;
        prod_c     = '0;
        idx_c      = 0;
        for (int l = 0; l < int'(LANES); l++) begin
            idx_c      = int'(beat_q) * int'(LANES) + l;
            prod_c     = $signed(datas_q[idx_c*N +: N]) * $signed(weights_q[idx_c*N +: N]);
            lane_sum_c = lane_sum_c + ACC_W'(prod_c >>> M);
        end
        acc_sum_c = acc_q + lane_sum_c;
        if (beat_q == LAST_BEAT) begin
            acc_sum_c = acc_sum_c + ACC_W'($signed(bias_q));
        end
    end

    neuron_activation #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_act (
        .sum        (acc_sum_c),
        .act_mode   (mode_q),
        .result_c   (act_result_c),
        .overflow_c (act_overflow_c)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        datas_d     = datas_q;
        weights_d   = weights_q;
        bias_d      = bias_q;
        mode_d      = mode_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc_d  = acc_sum_c;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        result_d    = act_result_c;
                        overflow_d  = act_overflow_c;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = accept_c ? ST_ACCUM : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Operand capture shared by IDLE and the OUTPUT back-to-back path.
            if (accept_c) begin
                datas_d   = datas;
                weights_d = weights;
                bias_d    = bias;
                mode_d    = act_mode;
                acc_d     = '0;
                beat_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            acc_q       <= '0;
            datas_q     <= '0;
            weights_q   <= '0;
            bias_q      <= '0;
            mode_q      <= ACT_IDENT;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            acc_q       <= acc_d;
            datas_q     <= datas_d;
            weights_q   <= weights_d;
            bias_q      <= bias_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_neuron_pipe.sv
// Self-checking bench for neuron_pipe (N=16, M=8, 4 inputs, 2 lanes) against an arithmetic model.
module tb_neuron_pipe;

    localparam int NI = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NI*16-1:0] datas = '0;
    logic [NI*16-1:0] weights = '0;
    logic [15:0]   bias = '0;
    logic [1:0]    act_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   result;
    logic          overflow;

    int n_cmp = 0;
    int n_fail = 0;

    neuron_pipe #(
        .N(16), .M(8), .NUM_INPUTS(NI), .LANES(2), .ACC_GUARD(12)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .datas(datas), .weights(weights), .bias(bias), .act_mode(act_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: exact integer dot product with floored Q8 products, activation, clamp.
    function automatic logic [16:0] model(input logic [NI*16-1:0] d, input logic [NI*16-1:0] w,
                                          input logic [15:0] b, input logic [1:0] m);
        longint s;
        longint p;
        s = longint'($signed(b));
        for (int i = 0; i < NI; i++) begin
            p = longint'($signed(d[i*16 +: 16])) * longint'($signed(w[i*16 +: 16]));
            s = s + (p >>> 8);
        end
        if (m == 2'b01 && s < 0) s = 0;
        else if (m == 2'b10 && s < 0) s = s >>> 3;
        if (s > 32767) return {1'b1, 16'h7FFF};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 2))
            0: return 16'($urandom);
            1: return 16'($signed(10'($urandom)));
            default: return $urandom_range(0, 1) ? 16'h7F00 : 16'h8100;
        endcase
    endfunction

    // Present a set at a negedge and hold it until accepted; afterwards scramble the inputs.
    task automatic accept_set(input logic [NI*16-1:0] d, input logic [NI*16-1:0] w,
                              input logic [15:0] b, input logic [1:0] m, output bit ok);
        bit got;
        ok = 1'b0;
        datas = d; weights = w; bias = b; act_mode = m; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            got = in_ready;
            @(posedge clk); @(negedge clk);
            if (got) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        datas = {$urandom, $urandom}; weights = {$urandom, $urandom};
        bias = 16'($urandom); act_mode = 2'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h ovf=%b, want 0 0 0000 0",
                     in_ready, out_valid, result, overflow);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        accept_set({4{16'h0100}}, {4{16'h0080}}, 16'h0040, 2'b01, ok);
        wait_out(n);
        n_cmp++;
        if (!ok || n != 2) begin
            n_fail++;
            $display("FAIL basic_latency: accepted=%0d edges=%0d, want 1 2", ok, n);
        end
        n_cmp++;
        if (result !== 16'h0240 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got %h/%b want 0240/0", result, overflow);
        end
        consume();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_modes();
        logic [15:0] exp_r[4];
        bit ok;
        int n;
        exp_r[0] = 16'hFC00; exp_r[1] = 16'h0000; exp_r[2] = 16'hFF80; exp_r[3] = 16'hFC00;
        for (int m = 0; m < 4; m++) begin
            accept_set({4{16'h0100}}, {4{16'hFF00}}, 16'h0000, 2'(m), ok);
            wait_out(n);
            n_cmp++;
            if (!ok || n != 2 || result !== exp_r[m] || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL mode_%0d: got %h/%b edges=%0d want %h/0 edges=2",
                         m, result, overflow, n, exp_r[m]);
            end
            consume();
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int n;
        accept_set({4{16'h7F00}}, {4{16'h7F00}}, 16'h0000, 2'b00, ok);
        wait_out(n);
        n_cmp++;
        if (!ok || result !== 16'h7FFF || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos: got %h/%b want 7fff/1", result, overflow);
        end
        consume();
        accept_set({4{16'h7F00}}, {4{16'h8100}}, 16'h0000, 2'b00, ok);
        wait_out(n);
        n_cmp++;
        if (!ok || result !== 16'h8000 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg: got %h/%b want 8000/1", result, overflow);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        accept_set({4{16'h0100}}, {4{16'h0080}}, 16'h0040, 2'b01, ok);
        wait_out(n);
        datas = {4{16'h0100}}; weights = {4{16'hFF00}}; bias = 16'h0; act_mode = 2'b00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 16'h0240) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: in_ready=%b out_valid=%b result=%h want 0 1 0240",
                         i, in_ready, out_valid, result);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        datas = {$urandom, $urandom};
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drop: out_valid=%b want 0", out_valid);
        end
        wait_out(n);
        n_cmp++;
        if (n != 2 || result !== 16'hFC00 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: got %h/%b edges=%0d want fc00/0 edges=2", result, overflow, n);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        accept_set({4{16'h0100}}, {4{16'h0080}}, 16'h0040, 2'b00, ok);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 16'h0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: out_valid=%b result=%h in_ready=%b want 0 0000 0",
                     out_valid, result, in_ready);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale_%0d: out_valid=%b want 0", i, out_valid);
            end
        end
        accept_set({4{16'h0100}}, {4{16'h0080}}, 16'h0040, 2'b01, ok);
        wait_out(n);
        n_cmp++;
        if (!ok || n != 2 || result !== 16'h0240) begin
            n_fail++;
            $display("FAIL rst_fresh: got %h edges=%0d want 0240 edges=2", result, n);
        end
        consume();
    endtask

    task automatic test_clk_en();
        bit ok;
        int n;
        int n2;
        accept_set({4{16'h0100}}, {4{16'h0080}}, 16'h0040, 2'b01, ok);
        clk_en = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        clk_en = 1'b1;
        wait_out(n2);
        n_cmp++;
        if (n + n2 != 5 || result !== 16'h0240 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clken_latency: got %h edges=%0d want 0240 edges=5", result, n + n2);
        end
        clk_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clken_ready: in_ready=%b want 0", in_ready);
        end
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 16'h0240) begin
            n_fail++;
            $display("FAIL clken_freeze: out_valid=%b result=%h want 1 0240", out_valid, result);
        end
        in_valid = 1'b0; clk_en = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clken_resume: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [NI*16-1:0] d;
        logic [NI*16-1:0] w;
        logic [15:0] b;
        logic [1:0] m;
        logic [16:0] exp_v;
        bit ok;
        int n;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NI; i++) begin
                d[i*16 +: 16] = rnd16();
                w[i*16 +: 16] = rnd16();
            end
            b = rnd16();
            m = 2'($urandom);
            exp_v = model(d, w, b, m);
            accept_set(d, w, b, m, ok);
            wait_out(n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            n_cmp++;
            if (!ok || n != 2 || result !== exp_v[15:0] || overflow !== exp_v[16]) begin
                n_fail++;
                $display("FAIL rand_%0d: got %h/%b edges=%0d want %h/%b edges=2 (mode %0d)",
                         t, result, overflow, n, exp_v[15:0], exp_v[16], m);
            end
            // Odd iterations present the next set on the consume edge.
            if (t[0]) out_ready = 1'b1;
            else consume();
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_clk_en();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
